// File: rtl/signed_mac_accumulator.sv
`timescale 1ns/1ps
// signed_mac_accumulator: sums num_terms signed products into a saturating
// ACC_W-bit accumulator, then holds the result until acc_ready.
//   clk, rst_n           : clock, async active-low reset
//   start, num_terms     : job request, sampled in IDLE
//   prod_in/valid/ready  : product input handshake
//   acc_out/valid/ready  : result output handshake
//   overflow             : sticky saturation flag for the current job
//   busy                 : high in ACCUM and DONE
module signed_mac_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  target;
  logic [ACC_W:0]    sum;
  logic              sat;
  logic [ACC_W-1:0]  sum_sat;
  logic              last_beat;

  // One guard bit: the add overflows exactly when the top two sum bits differ.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    sat     = sum[ACC_W] ^ sum[ACC_W-1];
    sum_sat = sum[ACC_W-1:0];
    if (sat) begin
      sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign last_beat = (count == target - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (acc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      target   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            count    <= '0;
            target   <= num_terms;
            overflow <= 1'b0;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc   <= sum_sat;
            count <= count + 1'b1;
            if (sat) begin
              overflow <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;

endmodule

// File: tb/tb_signed_mac_accumulator.sv
`timescale 1ns/1ps
module tb_signed_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_terms;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic        acc_ready;

  logic        prod_ready;
  logic [71:0] acc_out;
  logic        acc_valid;
  logic        overflow;
  logic        busy;

  logic        prod_ready65;
  logic [64:0] acc_out65;
  logic        acc_valid65;
  logic        overflow65;
  logic        busy65;

  int total;
  int bad;

  typedef struct {
    logic [15:0]      n;
    logic [3:0][63:0] p;
    logic [71:0]      e72;
    logic             o72;
    logic [64:0]      e65;
    logic             o65;
  } vec_t;

  vec_t vecs[$];

  signed_mac_accumulator #(
    .PROD_W(64),
    .ACC_W (72),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  signed_mac_accumulator #(
    .PROD_W(64),
    .ACC_W (65),
    .CNT_W (16)
  ) dut65 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready65),
    .acc_out   (acc_out65),
    .acc_valid (acc_valid65),
    .acc_ready (acc_ready),
    .overflow  (overflow65),
    .busy      (busy65)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] n, input logic [63:0] p0, input logic [63:0] p1,
                         input logic [63:0] p2, input logic [63:0] p3,
                         input logic [71:0] e72, input logic o72,
                         input logic [64:0] e65, input logic o65);
    vec_t v;
    v.n = n;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.e72 = e72; v.o72 = o72; v.e65 = e65; v.o65 = o65;
    vecs.push_back(v);
  endtask

  // Starts a job and feeds n beats; ends at the cycle after the last beat.
  task automatic run_job(input vec_t v, input bit stall);
    start     = 1'b1;
    num_terms = v.n;
    tick();
    start = 1'b0;
    chk("prod_ready_in_accum", {71'd0, prod_ready}, 72'd1);
    for (int i = 0; i < int'(v.n); i++) begin
      prod_valid = 1'b1;
      prod_in    = v.p[i];
      tick();
      prod_valid = 1'b0;
      if (i < int'(v.n) - 1) begin
        chk("no_early_valid", {71'd0, acc_valid}, 72'd0);
        if (stall) begin
          prod_in = 64'hDEAD_BEEF_DEAD_BEEF;
          tick();
          chk("stall_still_accum", {71'd0, prod_ready}, 72'd1);
        end
      end
    end
    prod_in = '0;
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("idle_after_ack_valid", {71'd0, acc_valid}, 72'd0);
    chk("idle_after_ack_busy", {71'd0, busy}, 72'd0);
  endtask

  initial begin
    vec_t v;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_terms  = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    acc_ready  = 1'b0;

    add_vec(16'd3, 64'h5, 64'hA, 64'hFFFF_FFFF_FFFF_FFFA, 64'h0,
            72'd9, 1'b0, 65'd9, 1'b0);
    add_vec(16'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 64'h0,
            72'd4, 1'b0, 65'd4, 1'b0);
    add_vec(16'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0,
            72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
    add_vec(16'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
            64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
            72'h00_FFFF_FFFF_FFFF_FFFD, 1'b0, 65'h0_7FFF_FFFF_FFFF_FFFF, 1'b1);
    add_vec(16'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
            64'h7FFF_FFFF_FFFF_FFFF, 64'h0,
            72'h01_7FFF_FFFF_FFFF_FFFD, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b1);
    add_vec(16'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h8000_0000_0000_0000, 64'h0,
            72'hFE_8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1);

    tick();
    tick();
    chk("rst_acc_out", acc_out, 72'd0);
    chk("rst_valid", {71'd0, acc_valid}, 72'd0);
    chk("rst_prod_ready", {71'd0, prod_ready}, 72'd0);
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_overflow", {71'd0, overflow}, 72'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < vecs.size(); k++) begin
      run_job(vecs[k], 1'b0);
      chk("vec_valid", {71'd0, acc_valid}, 72'd1);
      chk("vec_acc72", acc_out, vecs[k].e72);
      chk("vec_ovf72", {71'd0, overflow}, {71'd0, vecs[k].o72});
      chk("vec_acc65", {7'd0, acc_out65}, {7'd0, vecs[k].e65});
      chk("vec_ovf65", {71'd0, overflow65}, {71'd0, vecs[k].o65});
      handshake();
      chk("idle_hold_acc", acc_out, vecs[k].e72);
      chk("idle_hold_ovf65", {71'd0, overflow65}, {71'd0, vecs[k].o65});
      tick();
    end

    // Zero terms: straight to DONE, overflow cleared from the previous job.
    start     = 1'b1;
    num_terms = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_valid", {71'd0, acc_valid}, 72'd1);
    chk("zero_prod_ready", {71'd0, prod_ready}, 72'd0);
    chk("zero_acc", acc_out, 72'd0);
    chk("zero_acc65", {7'd0, acc_out65}, 72'd0);
    chk("zero_ovf65", {71'd0, overflow65}, 72'd0);
    handshake();
    tick();

    // Stalled input and held output.
    add_vec(16'd4, 64'd1, 64'd2, 64'd3, 64'd4, 72'd10, 1'b0, 65'd10, 1'b0);
    v = vecs[vecs.size()-1];
    run_job(v, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("stall_done_valid", {71'd0, acc_valid}, 72'd1);
      chk("stall_done_acc", acc_out, 72'd10);
      chk("stall_done_pready", {71'd0, prod_ready}, 72'd0);
      prod_valid = 1'b1;
      prod_in    = 64'd1000;
      tick();
      prod_valid = 1'b0;
    end
    chk("stall_done_acc_end", acc_out, 72'd10);
    handshake();
    chk("stall_idle_acc", acc_out, 72'd10);
    tick();

    // start during ACCUM is ignored; start with the output handshake too.
    start     = 1'b1;
    num_terms = 16'd2;
    tick();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 64'd100;
    tick();
    prod_valid = 1'b0;
    start      = 1'b1;
    num_terms  = 16'd9;
    tick();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 64'd200;
    tick();
    prod_valid = 1'b0;
    chk("busy_start_valid", {71'd0, acc_valid}, 72'd1);
    chk("busy_start_acc", acc_out, 72'd300);
    acc_ready = 1'b1;
    start     = 1'b1;
    num_terms = 16'd3;
    tick();
    acc_ready = 1'b0;
    start     = 1'b0;
    chk("ack_start_busy", {71'd0, busy}, 72'd0);
    tick();
    chk("ack_start_still_idle", {71'd0, busy}, 72'd0);

    // Reset mid-job after 2 of 5 beats.
    start     = 1'b1;
    num_terms = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in    = 64'd7 + 64'(i);
      tick();
    end
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc_out, 72'd0);
    chk("midrst_valid", {71'd0, acc_valid}, 72'd0);
    chk("midrst_pready", {71'd0, prod_ready}, 72'd0);
    chk("midrst_busy", {71'd0, busy}, 72'd0);
    chk("midrst_ovf", {71'd0, overflow}, 72'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_job(vecs[1], 1'b0);
    chk("post_rst_valid", {71'd0, acc_valid}, 72'd1);
    chk("post_rst_acc", acc_out, 72'd4);
    handshake();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
